// File: rtl/alu_op_driver.sv
// alu_op_driver: issues a burst of opcode/operand beats over req/ack and accumulates the results
module alu_op_driver #(
  parameter int NUM_OPS = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_base,
  input  logic [2:0] d_base,
  output logic       req,
  output logic [2:0] code,
  output logic [2:0] d,
  input  logic       ack,
  input  logic [3:0] res,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum,
  output logic [3:0] last_res,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;
  localparam logic [3:0] LAST_K = 4'(NUM_OPS - 1);
  localparam logic [7:0] LAST_W = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [3:0] k_q, k_d, last_res_q, last_res_d;
  logic [2:0] op_q, op_d, db_q, db_d, code_q, code_d, d_q, d_d, raw_code;
  logic [7:0] wait_q, wait_d, checksum_q, checksum_d;
  logic err_q, err_d, req_q, req_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    op_d = op_q;
    db_d = db_q;
    wait_d = wait_q;
    checksum_d = checksum_q;
    last_res_d = last_res_q;
    err_d = err_q;
    if (state_q == IDLE && start) begin
      state_d = REQ;
      k_d = 4'd0;
      op_d = op_base;
      db_d = d_base;
      wait_d = 8'd0;
      checksum_d = 8'd0;
      err_d = 1'b0;
    end
    if (state_q == REQ) begin
      if (ack) begin
        last_res_d = res;
        checksum_d = checksum_q + {4'd0, res};
        wait_d = 8'd0;
        state_d = (k_q == LAST_K) ? DONE : GAP;
        k_d = (k_q == LAST_K) ? k_q : k_q + 4'd1;
      end else if (wait_q == LAST_W) begin
        err_d = 1'b1;
        state_d = DONE;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
    if (state_q == GAP) state_d = REQ;
    if (state_q == DONE) state_d = IDLE;
    raw_code = op_d + k_d[2:0];
    req_d = state_d == REQ;
    busy_d = state_d == REQ || state_d == GAP;
    done_d = state_d == DONE;
    code_d = req_d ? ((raw_code == 3'd0) ? 3'd1 : raw_code) : 3'd0;
    d_d = req_d ? db_d + k_d[2:0] : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= 4'd0;
      op_q <= 3'd0;
      db_q <= 3'd0;
      wait_q <= 8'd0;
      checksum_q <= 8'd0;
      last_res_q <= 4'd0;
      err_q <= 1'b0;
      req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      code_q <= 3'd0;
      d_q <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      op_q <= op_d;
      db_q <= db_d;
      wait_q <= wait_d;
      checksum_q <= checksum_d;
      last_res_q <= last_res_d;
      err_q <= err_d;
      req_q <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
      code_q <= code_d;
      d_q <= d_d;
    end
  end
  assign req = req_q;
  assign code = code_q;
  assign d = d_q;
  assign busy = busy_q;
  assign done = done_q;
  assign checksum = checksum_q;
  assign last_res = last_res_q;
  assign err = err_q;
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: random and directed bursts against a spec-level burst model, two NUM_OPS configurations
module tb_alu_op_driver;
  localparam int TO = 16;
  localparam int NOPS [2] = '{4, 15};
  logic clk = 0, rst = 1;
  logic start_v [2], ack_v [2], req_v [2], busy_v [2], done_v [2], err_v [2];
  logic [2:0] ob_v [2], db_v [2], code_v [2], d_v [2];
  logic [3:0] res_v [2], last_v [2];
  logic [7:0] cs_v [2];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  alu_op_driver #(.NUM_OPS(4), .TIMEOUT(TO)) u0 (.clk(clk), .rst(rst), .start(start_v[0]), .op_base(ob_v[0]), .d_base(db_v[0]),
    .req(req_v[0]), .code(code_v[0]), .d(d_v[0]), .ack(ack_v[0]), .res(res_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .checksum(cs_v[0]), .last_res(last_v[0]), .err(err_v[0]));
  alu_op_driver #(.NUM_OPS(15), .TIMEOUT(TO)) u1 (.clk(clk), .rst(rst), .start(start_v[1]), .op_base(ob_v[1]), .d_base(db_v[1]),
    .req(req_v[1]), .code(code_v[1]), .d(d_v[1]), .ack(ack_v[1]), .res(res_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .checksum(cs_v[1]), .last_res(last_v[1]), .err(err_v[1]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int ecode(input int ob, input int i);
    int c = (ob + i) % 8;
    return (c == 0) ? 1 : c;
  endfunction
  task automatic all_zero(input int s, input string tag);
    chk({tag, "_req"}, 32'(req_v[s]), 0);
    chk({tag, "_code"}, 32'(code_v[s]), 0);
    chk({tag, "_d"}, 32'(d_v[s]), 0);
    chk({tag, "_busy"}, 32'(busy_v[s]), 0);
    chk({tag, "_done"}, 32'(done_v[s]), 0);
    chk({tag, "_cs"}, 32'(cs_v[s]), 0);
    chk({tag, "_last"}, 32'(last_v[s]), 0);
    chk({tag, "_err"}, 32'(err_v[s]), 0);
  endtask
  // One burst: per-beat waits/results chosen here, expected values derived from beat index arithmetic
  task automatic burst(input int s, input int ob, input int db, input int minw, input int maxw,
                       input int fres, input int stall, input bit poke);
    int n = NOPS[s];
    int cs = 0, edges = 0, sumw = 0, w, r, lr = 0;
    bit stopped = 0;
    @(negedge clk);
    start_v[s] = 1; ob_v[s] = 3'(ob); db_v[s] = 3'(db);
    @(posedge clk); edges++;
    @(negedge clk);
    start_v[s] = 0; ob_v[s] = 3'($urandom); db_v[s] = 3'($urandom);
    chk("err_clr", 32'(err_v[s]), 0);
    chk("cs_clr", 32'(cs_v[s]), 0);
    for (int i = 0; i < n && !stopped; i++) begin
      w = (i == stall) ? TO : int'($urandom_range(maxw, minw));
      r = (fres < 0) ? int'($urandom_range(15, 0)) : fres;
      for (int j = 0; j < w; j++) begin
        chk("wait_req", 32'(req_v[s]), 1);
        chk("wait_busy", 32'(busy_v[s]), 1);
        chk("wait_code", 32'(code_v[s]), ecode(ob, i));
        chk("wait_d", 32'(d_v[s]), (db + i) % 8);
        ack_v[s] = 0; res_v[s] = 4'($urandom);
        @(posedge clk); edges++;
        @(negedge clk);
      end
      if (i == stall) begin
        chk("to_done", 32'(done_v[s]), 1);
        chk("to_err", 32'(err_v[s]), 1);
        chk("to_cs", 32'(cs_v[s]), cs);
        chk("to_lat", edges, 1 + 2 * i + sumw + TO);
        chk("to_req", 32'(req_v[s]), 0);
        stopped = 1;
      end else begin
        sumw += w;
        chk("req", 32'(req_v[s]), 1);
        chk("code", 32'(code_v[s]), ecode(ob, i));
        chk("d", 32'(d_v[s]), (db + i) % 8);
        ack_v[s] = 1; res_v[s] = 4'(r);
        @(posedge clk); edges++;
        @(negedge clk);
        ack_v[s] = 0;
        cs = (cs + r) % 256; lr = r;
        chk("last_res", 32'(last_v[s]), r);
        chk("checksum", 32'(cs_v[s]), cs);
        if (i < n - 1) begin
          chk("gap_req", 32'(req_v[s]), 0);
          chk("gap_busy", 32'(busy_v[s]), 1);
          chk("gap_code", 32'(code_v[s]), 0);
          chk("gap_done", 32'(done_v[s]), 0);
          if (poke) begin
            ack_v[s] = 1; res_v[s] = 4'($urandom); start_v[s] = 1;
          end
          @(posedge clk); edges++;
          @(negedge clk);
          ack_v[s] = 0; start_v[s] = 0;
        end else begin
          chk("done", 32'(done_v[s]), 1);
          chk("latency", edges, 2 * n + sumw);
          chk("done_busy", 32'(busy_v[s]), 0);
          chk("done_err", 32'(err_v[s]), 0);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", 32'(done_v[s]), 0);
    chk("hold_cs", 32'(cs_v[s]), cs);
    chk("hold_last", 32'(last_v[s]), lr);
    chk("hold_err", 32'(err_v[s]), stopped);
  endtask
  initial begin
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 0; ack_v[s] = 1; res_v[s] = 4'hf; ob_v[s] = 0; db_v[s] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    all_zero(0, "rst0");
    all_zero(1, "rst1");
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_zero(0, "idle_ack");
    ack_v[0] = 0; ack_v[1] = 0;
    burst(0, 0, 2, 0, 0, 3, -1, 0);
    chk("zw_cs12", 32'(cs_v[0]), 12);
    burst(0, 6, 7, 2, 2, 15, -1, 0);
    chk("wrap_cs60", 32'(cs_v[0]), 60);
    burst(1, 3, 5, 0, 1, 15, -1, 1);
    chk("big_cs225", 32'(cs_v[1]), 225);
    burst(1, 0, 0, 0, 0, 15, -1, 0);
    chk("big_cs225b", 32'(cs_v[1]), 225);
    burst(0, 2, 4, 0, 1, -1, 2, 0);
    burst(0, 5, 1, 0, 0, -1, -1, 0);
    for (int t = 0; t < 8; t++)
      burst(t % 2, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), 0, 3, -1,
            (t % 3 == 2) ? int'($urandom_range(NOPS[t % 2] - 1, 0)) : -1, 1'($urandom));
    @(negedge clk);
    start_v[0] = 1; ob_v[0] = 1; db_v[0] = 1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 0; ack_v[0] = 1; res_v[0] = 5;
    @(posedge clk);
    @(negedge clk);
    ack_v[0] = 0; start_v[0] = 1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 0;
    chk("mr_req", 32'(req_v[0]), 1);
    chk("mr_code", 32'(code_v[0]), 2);
    chk("mr_d", 32'(d_v[0]), 2);
    rst = 1; start_v[0] = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0; start_v[0] = 0;
    all_zero(0, "midrst");
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_done", 32'(done_v[0]), 0);
      chk("post_rst_req", 32'(req_v[0]), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Initiator side of the opcode/operand ALU interface. On a `start` pulse it issues a burst of `NUM_OPS` operation beats (3-bit code plus 3-bit operand `d`) to a result-producing ALU responder over a req/ack handshake, captures each 4-bit result, and accumulates a running checksum. It sits upstream of the ALU blocks in the Blocking/Non-Blocking exercise set and serves as their stimulus and collection engine.

## Interface
- `NUM_OPS`, 4: beats per burst; legal range 1..15.
- `TIMEOUT`, 16: consecutive unacknowledged request cycles before abort; legal range 2..255.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  burst request; accepted only in IDLE.
- `op_base`  in  3  base operation code, sampled on accepted start.
- `d_base`  in  3  base operand, sampled on accepted start.
- `req`  out  1  beat valid toward responder.
- `code`  out  3  operation code for current beat.
- `d`  out  3  operand for current beat.
- `ack`  in  1  responder result valid; meaningful only while `req`=1.
- `res`  in  4  responder result, sampled when `req`&`ack`.
- `busy`  out  1  high in REQ and GAP.
- `done`  out  1  one-cycle pulse at burst end (normal or abort).
- `checksum`  out  8  running sum of captured results.
- `last_res`  out  4  most recently captured result.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE: `start`=1 -> latch bases, clear beat counter `k`, `checksum`, `err`, wait counter; go REQ.
- REQ: `req`=1; `code` = (op_base + k) mod 8, except that a result of 3'b000 is driven as 3'b001 (000 is a no-op code on the responder); `d` = (d_base + k) mod 8.
  - `ack`=1: `last_res`<=`res`, `checksum`<=`checksum`+`res` (zero-extended, wraps mod 256), clear wait counter; if k = NUM_OPS-1 -> DONE, else k++ -> GAP.
  - `ack`=0: wait counter++; when the TIMEOUT-th consecutive unacked REQ cycle ends -> `err`<=1, go DONE. No result is captured.
- GAP: `req`=0 for exactly one cycle; -> REQ.
- DONE: `done`=1 for one cycle; -> IDLE.
- `code`/`d` are held stable for the whole REQ interval of a beat; they are 0 outside REQ.
- `ack` in IDLE/GAP/DONE is ignored.
- `start` outside IDLE is ignored (no queuing).
- `checksum`, `last_res` and `err` hold their values after DONE until the next accepted start or reset.

## Timing
- Reset values: state IDLE, `req`=0, `code`=0, `d`=0, `busy`=0, `done`=0, `checksum`=0, `last_res`=0, `err`=0, `k`=0.
- `rst` mid-burst: all of the above take effect at that edge; the burst is abandoned. `rst` has priority over `start` at the same edge.
- `start` sampled at edge E0 -> `req` high in the cycle after E0.
- Acked at the same edge as asserted: a beat occupies 1 REQ cycle + 1 GAP cycle.
- Zero-wait burst: `done` asserted 2·NUM_OPS cycles after the start edge; total latency = 2·NUM_OPS + Σ wait cycles.
- Back-to-back bursts: `start` can be accepted in the cycle after `done` (IDLE) at the earliest.
- Result capture and the checksum update are registered: visible in the cycle after the ack edge.

## Test plan
- Reset: assert `rst` for 2 cycles -> every output 0, state IDLE; `ack`=1 while idle -> no change.
- Zero-wait burst: NUM_OPS=4, op_base=0, d_base=2, responder acks immediately with `res`=3 -> code sequence 1,1,2,3; d sequence 2,3,4,5; `checksum`=12; `last_res`=3; `done` 8 cycles after start; `err`=0.
- Wrap and wait states: op_base=6, d_base=7, ack delayed 2 cycles per beat, `res`=15 -> codes 6,7,1,1; d 7,0,1,2; `checksum`=60; `done` 16 cycles after start; code/d held steady during waits.
- Checksum wrap: NUM_OPS=15, `res`=15 on every beat -> `checksum`=225; a second burst with `res`=15 starts again from 0 and ends at 225 (no carry-in from the previous burst).
- Timeout: TIMEOUT=16, `ack` held 0 on beat 2 -> `err`=1 after 16 REQ cycles, `done` pulses, checksum covers beats 0..1 only; next start clears `err`.
- Mid-burst reset and ignored start: pulse `start` during GAP -> no effect; assert `rst` during REQ of beat 1 -> IDLE with all outputs 0 at the next cycle, no `done`.
